// File: rtl/led_blink_indicator.sv
// led_blink_indicator: queues single-cycle event strobes and replays each one as a timed LED blink
// followed by a dark gap, with a saturating pending counter and a sticky overflow flag.
module led_blink_indicator #(
   parameter int CLK_DIV   = 128000,
   parameter int ON_TICKS  = 100,
   parameter int OFF_TICKS = 100,
   parameter int PEND_W    = 4
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_event,
   input  logic              i_enable,
   input  logic              i_clr_ovf,
   output logic              o_led,
   output logic              o_busy,
   output logic [PEND_W-1:0] o_pending,
   output logic              o_overflow
);
   localparam int PW = $clog2(CLK_DIV);
   localparam int MT = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
   localparam int TW = $clog2(MT + 1);
   localparam logic [PEND_W-1:0] PMAX = '1;
   typedef enum logic [1:0] {IDLE, ON, GAP} state_t;
   state_t            state, state_nxt;
   logic [PW-1:0]     presc, presc_nxt;
   logic [TW-1:0]     tcnt, tcnt_nxt;
   logic [PEND_W-1:0] pend_nxt;
   logic              tick, done, consume, accept, lost, ovf_nxt;
   always_comb begin
      tick      = (state != IDLE) && (presc == PW'(CLK_DIV - 1));
      done      = tick && (tcnt == ((state == ON) ? TW'(ON_TICKS - 1) : TW'(OFF_TICKS - 1)));
      consume   = (state == IDLE) && (o_pending != '0) && i_enable;
      // an event at full queue is still taken when a blink is consumed in the same cycle
      accept    = i_event && ((o_pending != PMAX) || consume);
      lost      = i_event && (o_pending == PMAX) && !consume;
      state_nxt = (state == IDLE) ? (consume ? ON : IDLE) :
                  (state == ON)   ? (done ? GAP : ON) :
                                    (done ? IDLE : GAP);
      presc_nxt = ((state_nxt != state) || (state_nxt == IDLE) || tick) ? '0 : presc + PW'(1);
      tcnt_nxt  = ((state_nxt != state) || (state_nxt == IDLE)) ? '0 : tick ? tcnt + TW'(1) : tcnt;
      pend_nxt  = o_pending + PEND_W'(accept) - PEND_W'(consume);
      ovf_nxt   = lost ? 1'b1 : i_clr_ovf ? 1'b0 : o_overflow;
   end
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state      <= IDLE;
         presc      <= '0;
         tcnt       <= '0;
         o_pending  <= '0;
         o_overflow <= 1'b0;
         o_led      <= 1'b0;
      end else begin
         state      <= state_nxt;
         presc      <= presc_nxt;
         tcnt       <= tcnt_nxt;
         o_pending  <= pend_nxt;
         o_overflow <= ovf_nxt;
         o_led      <= (state_nxt == ON);
      end
   end
   assign o_busy = (state != IDLE);
endmodule
